// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 8x8 register bank and its
// write-select checker.
package regfile_pkg;

    localparam int RF_WIDTH    = 8;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_ADDR_W   = 3;
    localparam int RF_CNT_W    = 8;

    typedef logic [RF_WIDTH-1:0]    rf_word_t;
    typedef logic [RF_NUM_REGS-1:0] rf_sel_t;
    typedef logic [RF_ADDR_W-1:0]   rf_addr_t;

    // Number of asserted select lines; 4 bits covers 0..8.
    function automatic logic [3:0] rf_sel_count(input rf_sel_t sel);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < RF_NUM_REGS; i++) begin
            cnt = cnt + {3'b000, sel[i]};
        end
        return cnt;
    endfunction

    // OR-encodes a select vector; the result is only meaningful when one-hot.
    function automatic rf_addr_t rf_sel_encode(input rf_sel_t sel);
        rf_addr_t idx;
        idx = {RF_ADDR_W{1'b0}};
        for (int i = 0; i < RF_NUM_REGS; i++) begin
            if (sel[i]) begin
                idx = idx | RF_ADDR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/regfile_onehot_chk.sv
// Classifies a decoder select vector (zero / one-hot / multi-hot) and
// encodes the selected index.
module regfile_onehot_chk
    import regfile_pkg::*;
(
    input  logic [RF_NUM_REGS-1:0] wsel,
    output logic                   is_onehot,
    output logic                   is_zero,
    output logic [RF_ADDR_W-1:0]   idx
);

    logic [3:0] count_s;

    // Population count drives both classifications; encode is independent.
    always_comb begin
        count_s   = rf_sel_count(wsel);
        is_zero   = (count_s == 4'd0);
        is_onehot = (count_s == 4'd1);
        idx       = rf_sel_encode(wsel);
    end

endmodule

// File: rtl/regfile_8x8_wr.sv
// 8-entry register bank written through one-hot decoder selects, with two
// registered read ports, write-to-read bypass, sticky select error and a
// saturating write counter.
module regfile_8x8_wr
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int CNT_W    = RF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [NUM_REGS-1:0] wsel,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [WIDTH-1:0]    rdata_a,
    output logic [WIDTH-1:0]    rdata_b,
    output logic                sel_err,
    input  logic                clr_err,
    output logic [CNT_W-1:0]    wr_cnt
);

    logic [WIDTH-1:0]  regs_r [NUM_REGS];
    logic [WIDTH-1:0]  rdata_a_r;
    logic [WIDTH-1:0]  rdata_b_r;
    logic              sel_err_r;
    logic [CNT_W-1:0]  wr_cnt_r;

    logic              is_onehot_s;
    logic              is_zero_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic              wr_ok_s;
    logic              multi_s;
    logic              cnt_sat_s;
    logic [WIDTH-1:0]  rd_next_a_s;
    logic [WIDTH-1:0]  rd_next_b_s;

    regfile_onehot_chk u_chk (
        .wsel      (wsel),
        .is_onehot (is_onehot_s),
        .is_zero   (is_zero_s),
        .idx       (wr_idx_s)
    );

    // Write qualification and per-port bypass selection.
    always_comb begin
        wr_ok_s   = we & is_onehot_s;
        multi_s   = we & ~is_onehot_s & ~is_zero_s;
        cnt_sat_s = (wr_cnt_r == {CNT_W{1'b1}});
        if (wr_ok_s && (wr_idx_s == raddr_a)) begin
            rd_next_a_s = wdata;
        end else begin
            rd_next_a_s = regs_r[raddr_a];
        end
        if (wr_ok_s && (wr_idx_s == raddr_b)) begin
            rd_next_b_s = wdata;
        end else begin
            rd_next_b_s = regs_r[raddr_b];
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_idx_s] <= wdata;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_r <= {WIDTH{1'b0}};
            rdata_b_r <= {WIDTH{1'b0}};
        end else begin
            rdata_a_r <= rd_next_a_s;
            rdata_b_r <= rd_next_b_s;
        end
    end

    // Sticky select error; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (multi_s) begin
            sel_err_r <= 1'b1;
        end else if (clr_err) begin
            sel_err_r <= 1'b0;
        end
    end

    // Saturating count of accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r <= {CNT_W{1'b0}};
        end else if (wr_ok_s && !cnt_sat_s) begin
            wr_cnt_r <= wr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;
    assign sel_err = sel_err_r;
    assign wr_cnt  = wr_cnt_r;

endmodule
